div_mod_top_level: RTL and testbench
====================================

# div_mod_top_level

Sequential signed integer divider: 32-bit signed dividend by 16-bit signed divisor, returning either the truncated quotient or the remainder as a 17-bit signed result. It uses a radix-2 shift-subtract loop on magnitudes, one bit per cycle, with a single-cycle valid handshake on each side. It is the top level of the divider block and is instantiated directly by system logic.

## Interface
- No parameters; widths are fixed constants (dividend 32, divisor 16, result 17, iterations 32).
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- dividend  input  32  signed two's-complement dividend; sampled only on the accept edge.
- divisor  input  16  signed two's-complement divisor; sampled only on the accept edge.
- mode  input  1  1 = quotient, 0 = remainder; sampled only on the accept edge.
- valid_input  input  1  request; accepted only in IDLE.
- valid_output  output  1  one-cycle pulse marking final_output as a new result.
- final_output  output  17  signed result, registered; held until the next result or reset.

## Operation
- Semantics are C-style truncation toward zero.
  - Quotient = trunc(dividend/divisor).
  - Remainder = dividend − quotient·divisor; its sign follows the dividend.
- Accept: on an edge in IDLE with valid_input=1, latch the following, clear the counter, and go to CALC:
  - |dividend| (33-bit safe for −2^31) and |divisor|;
  - sign_q = sign(dividend) XOR sign(divisor);
  - sign_r = sign(dividend);
  - mode.
- CALC: 32 edges. Each edge shifts the partial remainder left by one and brings in the next dividend MSB. If partial ≥ |divisor|, subtract and set the quotient bit to 1, otherwise set it to 0. After the 32nd edge, go to SIGN.
- SIGN: one edge. Apply signs, then select and register the result:
  - Quotient: negate the magnitude if sign_q. Saturate to the 17-bit range [−65536, 65535]. This covers any |quotient| too large, including −2^31/−1 → 65535.
  - Remainder: negate if sign_r. The magnitude is always < 2^15, so no saturation is needed.
  - Divide by zero: quotient = −1 (17'h1FFFF), remainder = 0. Same latency as a normal operation.
  - Register final_output and set valid_output=1. Return to IDLE.
- IDLE: valid_output is cleared on the next edge.
- Inputs are ignored while in CALC or SIGN. No queuing and no back-pressure.

## Timing
- Reset (synchronous; wins over all other activity): state=IDLE, valid_output=0, final_output=0, datapath registers cleared.
- Reset mid-operation: the operation is aborted, no valid_output is produced, and the block is in IDLE on the next cycle.
- Latency, with accept edge E0:
  - CALC edges E1–E32.
  - SIGN edge E33 sets valid_output=1 and final_output.
  - valid_output drops at E34.
- Throughput: with valid_input held high, E34 accepts the next operation. That gives one result every 34 cycles, and each result produces exactly one pulse.
- final_output changes only at a SIGN edge or on reset.

## Structure
- Shared package div_mod_pkg:
  - width constants DIVIDEND_W=32, DIVISOR_W=16, RESULT_W=17, ITER=32;
  - state enum {IDLE, CALC, SIGN};
  - mode encodings MODE_QUOT=1, MODE_REM=0.
- One sub-module: div_mod_core. It is an unsigned 32/16 shift-subtract iterator (start, step, quotient, remainder). The top level owns the FSM, sign handling, saturation and output registers.

## Test plan
- dividend=80, divisor=−3, mode=1, valid_input held high after reset → valid_output pulses 34 cycles after accept with final_output=−26; pulses repeat every 34 cycles.
- 80 / −3, mode=0 → 2. −80 / 3, mode=0 → −2. −80 / −3, mode=1 → 26.
- 100000 / 1, mode=1 → 65535 (saturated). −2147483648 / −1, mode=1 → 65535. −2147483648 / 1 → −65536.
- Divisor=0, dividend=1234: mode=1 → −1; mode=0 → 0; latency unchanged.
- Assert reset at cycle 10 of an operation → valid_output stays 0, final_output=0. A new request after reset completes normally.
- Change dividend/divisor/mode during CALC → result reflects the values captured at accept; valid_input pulses during busy are dropped.

Source files
------------

// File: rtl/div_mod_pkg.sv
// Shared constants, state encoding and magnitude helpers for the signed divider.
package div_mod_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int RESULT_W   = 17;
  localparam int ITER       = 32;
  localparam int CNT_W      = 6;

  // Counter value seen on the final CALC edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic MODE_QUOT = 1'b1;
  localparam logic MODE_REM  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_e;

  // Unsigned magnitude of a two's-complement dividend; -2^31 maps to 2^31,
  // which still fits in 32 unsigned bits.
  function automatic logic [DIVIDEND_W-1:0] mag_dividend(input logic [DIVIDEND_W-1:0] v);
    if (v[DIVIDEND_W-1]) begin
      mag_dividend = ~v + 32'd1;
    end else begin
      mag_dividend = v;
    end
  endfunction

  // Unsigned magnitude of a two's-complement divisor; -2^15 maps to 2^15.
  function automatic logic [DIVISOR_W-1:0] mag_divisor(input logic [DIVISOR_W-1:0] v);
    if (v[DIVISOR_W-1]) begin
      mag_divisor = ~v + 16'd1;
    end else begin
      mag_divisor = v;
    end
  endfunction

endpackage

// File: rtl/div_mod_core.sv
// Unsigned 32/16 restoring shift-subtract iterator: one quotient bit per step.
// The quotient register doubles as the dividend shifter: its MSB feeds the
// partial remainder and the new quotient bit enters at the LSB.
module div_mod_core
  import div_mod_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  step_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o
);

  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  div_q, div_d;
  logic [DIVISOR_W:0]    shifted_s;
  logic [DIVISOR_W-1:0]  diff_s;
  logic                  ge_s;

  // Next-state datapath: load on start, one shift-subtract per step, else hold.
  always_comb begin
    shifted_s = {rem_q, quo_q[DIVIDEND_W-1]};
    ge_s      = (shifted_s >= {1'b0, div_q});
    // When ge_s is set the true difference is below div_q, so 16 bits suffice.
    diff_s    = shifted_s[DIVISOR_W-1:0] - div_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = {DIVISOR_W{1'b0}};
      div_d = divisor_i;
    end else if (step_i) begin
      quo_d = {quo_q[DIVIDEND_W-2:0], ge_s};
      if (ge_s) begin
        rem_d = diff_s;
      end else begin
        rem_d = shifted_s[DIVISOR_W-1:0];
      end
    end else begin
      quo_d = quo_q;
    end
  end

  // Datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= {DIVIDEND_W{1'b0}};
      rem_q <= {DIVISOR_W{1'b0}};
      div_q <= {DIVISOR_W{1'b0}};
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      div_q <= div_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/div_mod_top_level.sv
// Sequential signed divider: 32-bit dividend / 16-bit divisor, truncating,
// returning a saturated 17-bit quotient or the remainder. Control FSM, sign
// handling and output registers live here; the magnitude loop is in the core.
module div_mod_top_level
  import div_mod_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic                  mode,
  input  logic                  valid_input,
  output logic                  valid_output,
  output logic [RESULT_W-1:0]   final_output
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 mode_q, mode_d;
  logic                 div_zero_q, div_zero_d;
  logic                 valid_q, valid_d;
  logic [RESULT_W-1:0]  result_q, result_d;

  logic                  accept_s;
  logic                  step_s;
  logic [DIVIDEND_W-1:0] quo_mag_s;
  logic [DIVISOR_W-1:0]  rem_mag_s;
  logic [RESULT_W-1:0]   quo_res_s;
  logic [RESULT_W-1:0]   rem_res_s;
  logic [RESULT_W-1:0]   sel_res_s;

  assign accept_s = (state_q == IDLE) && valid_input;
  assign step_s   = (state_q == CALC);

  div_mod_core u_core (
    .clk         (clk),
    .reset       (reset),
    .start_i     (accept_s),
    .step_i      (step_s),
    .dividend_i  (mag_dividend(dividend)),
    .divisor_i   (mag_divisor(divisor)),
    .quotient_o  (quo_mag_s),
    .remainder_o (rem_mag_s)
  );

  // Apply signs, saturate the quotient to 17 bits and pick the requested result.
  always_comb begin
    quo_res_s = {RESULT_W{1'b0}};
    rem_res_s = {RESULT_W{1'b0}};
    sel_res_s = {RESULT_W{1'b0}};
    if (neg_quo_q) begin
      if (quo_mag_s > 32'd65536) begin
        quo_res_s = 17'h10000;
      end else begin
        quo_res_s = ~quo_mag_s[RESULT_W-1:0] + 17'd1;
      end
    end else begin
      if (quo_mag_s > 32'd65535) begin
        quo_res_s = 17'h0FFFF;
      end else begin
        quo_res_s = quo_mag_s[RESULT_W-1:0];
      end
    end
    // |remainder| < 2^15 always, so negation cannot overflow 17 bits.
    if (neg_rem_q) begin
      rem_res_s = ~{1'b0, rem_mag_s} + 17'd1;
    end else begin
      rem_res_s = {1'b0, rem_mag_s};
    end
    if (div_zero_q) begin
      if (mode_q == MODE_QUOT) begin
        sel_res_s = 17'h1FFFF;
      end else begin
        sel_res_s = 17'h00000;
      end
    end else if (mode_q == MODE_QUOT) begin
      sel_res_s = quo_res_s;
    end else begin
      sel_res_s = rem_res_s;
    end
  end

  // Next-state logic: accept in IDLE, count 32 CALC edges, publish in SIGN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    mode_d     = mode_q;
    div_zero_d = div_zero_q;
    valid_d    = 1'b0;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (valid_input) begin
          state_d    = CALC;
          cnt_d      = {CNT_W{1'b0}};
          neg_quo_d  = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
          neg_rem_d  = dividend[DIVIDEND_W-1];
          mode_d     = mode;
          div_zero_d = (divisor == 16'd0);
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = SIGN;
        end else begin
          state_d = CALC;
        end
      end
      SIGN: begin
        valid_d  = 1'b1;
        result_d = sel_res_s;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      mode_q     <= 1'b0;
      div_zero_q <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= {RESULT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      mode_q     <= mode_d;
      div_zero_q <= div_zero_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
    end
  end

  assign valid_output = valid_q;
  assign final_output = result_q;

endmodule

// File: tb/tb_div_mod_top_level.sv
// Self-checking bench for div_mod_top_level with a plain-arithmetic reference.
module tb_div_mod_top_level;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        mode;
  logic        valid_input;
  logic        valid_output;
  logic [16:0] final_output;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_mod_top_level dut (
    .clk          (clk),
    .reset        (reset),
    .dividend     (dividend),
    .divisor      (divisor),
    .mode         (mode),
    .valid_input  (valid_input),
    .valid_output (valid_output),
    .final_output (final_output)
  );

  // C-style truncating division with 17-bit quotient saturation.
  function automatic logic [16:0] ref_model(input logic signed [31:0] a,
                                            input logic signed [15:0] b,
                                            input logic m);
    longint la, lb, q, r;
    la = a;
    lb = b;
    if (lb == 0) return m ? 17'h1FFFF : 17'h00000;
    q = la / lb;
    r = la % lb;
    if (m) begin
      if (q > 65535) q = 65535;
      if (q < -65536) q = -65536;
      return q[16:0];
    end
    return r[16:0];
  endfunction

  // Present one request for a single accept edge, leaving valid_input low.
  task automatic start_op(input logic [31:0] a, input logic [15:0] b, input logic m);
    @(negedge clk);
    dividend = a; divisor = b; mode = m; valid_input = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_input = 1'b0;
  endtask

  // Wait (bounded) for valid_output; lat counts edges after the accept edge.
  task automatic wait_result(output logic [16:0] res, output int lat, output logic seen);
    lat = 0;
    while (!valid_output && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    seen = valid_output;
    res  = final_output;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input logic m,
                        output logic [16:0] res, output int lat, output logic seen,
                        output logic v_next, output logic [16:0] res_next);
    start_op(a, b, m);
    wait_result(res, lat, seen);
    @(posedge clk);
    @(negedge clk);
    v_next   = valid_output;
    res_next = final_output;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_input = 1'b0; dividend = 32'd0; divisor = 16'd0; mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (valid_output !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", valid_output);
    end
    total++;
    if (final_output !== 17'h00000) begin
      bad++; $display("FAIL reset_result: got %h want 00000", final_output);
    end
  endtask

  typedef struct { int a; int b; bit m; } vec_t;

  task automatic test_directed();
    vec_t vecs[$];
    logic [16:0] res, res_next, exp;
    int lat;
    logic seen, v_next;
    vecs.push_back('{80, -3, 1'b1});
    vecs.push_back('{80, -3, 1'b0});
    vecs.push_back('{-80, 3, 1'b0});
    vecs.push_back('{-80, -3, 1'b1});
    vecs.push_back('{100000, 1, 1'b1});
    vecs.push_back('{32'h8000_0000, -1, 1'b1});
    vecs.push_back('{32'h8000_0000, 1, 1'b1});
    vecs.push_back('{32'h7FFF_FFFF, -32768, 1'b0});
    vecs.push_back('{-7, 32767, 1'b1});
    foreach (vecs[i]) begin
      run_op(vecs[i].a, 16'(vecs[i].b), vecs[i].m, res, lat, seen, v_next, res_next);
      exp = ref_model(vecs[i].a, 16'(vecs[i].b), vecs[i].m);
      total++;
      if (!seen || lat != 33) begin
        bad++; $display("FAIL directed_latency[%0d]: got %0d (seen=%b) want 33", i, lat, seen);
      end
      total++;
      if (res !== exp) begin
        bad++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, exp);
      end
      total++;
      if (v_next !== 1'b0 || res_next !== exp) begin
        bad++; $display("FAIL directed_pulse[%0d]: valid=%b res=%h want 0/%h", i, v_next, res_next, exp);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [16:0] res, res_next;
    int lat;
    logic seen, v_next;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = (i < 2) ? 32'd1234 : $urandom;
      run_op(a, 16'd0, i[0] ? 1'b0 : 1'b1, res, lat, seen, v_next, res_next);
      total++;
      if (!seen || lat != 33) begin
        bad++; $display("FAIL divzero_latency[%0d]: got %0d want 33", i, lat);
      end
      total++;
      if (res !== (i[0] ? 17'h00000 : 17'h1FFFF)) begin
        bad++; $display("FAIL divzero_result[%0d]: got %h want %h", i, res, i[0] ? 17'h00000 : 17'h1FFFF);
      end
    end
  endtask

  task automatic test_random();
    logic [16:0] res, res_next, exp;
    int lat;
    logic seen, v_next;
    logic [31:0] a;
    logic [15:0] b;
    logic m;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a = 32'($signed(16'($urandom)));
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) b = -16'($urandom_range(1, 20));
      m = 1'($urandom);
      run_op(a, b, m, res, lat, seen, v_next, res_next);
      exp = ref_model(a, b, m);
      total++;
      if (!seen || res !== exp || lat != 33) begin
        bad++;
        $display("FAIL random[%0d] %0d/%0d m=%b: got %h lat %0d want %h lat 33",
                 i, $signed(a), $signed(b), m, res, lat, exp);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [16:0] res, res_next, exp;
    int lat, saw;
    logic seen, v_next;
    run_op(32'd100, 16'd7, 1'b1, res, lat, seen, v_next, res_next);
    start_op(32'd80, -16'sd3, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (valid_output !== 1'b0 || final_output !== 17'h00000) begin
      bad++; $display("FAIL midreset_state: valid=%b res=%h want 0/00000", valid_output, final_output);
    end
    saw = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_output) saw++;
    end
    total++;
    if (saw != 0 || final_output !== 17'h00000) begin
      bad++; $display("FAIL midreset_quiet: pulses=%0d res=%h want 0/00000", saw, final_output);
    end
    run_op(32'd1234, 16'd7, 1'b1, res, lat, seen, v_next, res_next);
    exp = ref_model(32'd1234, 16'd7, 1'b1);
    total++;
    if (!seen || lat != 33 || res !== exp) begin
      bad++; $display("FAIL midreset_recover: got %h lat %0d want %h lat 33", res, lat, exp);
    end
  endtask

  task automatic test_busy_ignore();
    logic [16:0] exp;
    int lat, saw;
    logic [31:0] a;
    logic [15:0] b;
    a = -32'sd1000000;
    b = 16'd77;
    exp = ref_model(a, b, 1'b0);
    start_op(a, b, 1'b0);
    lat = 0;
    while (!valid_output && lat < 60) begin
      dividend = $urandom; divisor = 16'($urandom); mode = 1'($urandom);
      valid_input = (lat == 5 || lat == 20);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    valid_input = 1'b0;
    total++;
    if (!valid_output || lat != 33 || final_output !== exp) begin
      bad++; $display("FAIL busy_capture: got %h lat %0d want %h lat 33", final_output, lat, exp);
    end
    saw = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_output) saw++;
    end
    total++;
    if (saw != 0) begin
      bad++; $display("FAIL busy_dropped: extra pulses %0d want 0", saw);
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    int cyc;
    logic [16:0] exp;
    exp = ref_model(32'd80, -16'sd3, 1'b1);
    @(negedge clk);
    dividend = 32'd80; divisor = -16'sd3; mode = 1'b1; valid_input = 1'b1;
    // cyc = 1 is the accept edge E0.
    for (cyc = 1; cyc <= 110; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_output) begin
        pulses.push_back(cyc);
        total++;
        if (final_output !== exp) begin
          bad++; $display("FAIL b2b_result at cyc %0d: got %h want %h", cyc, final_output, exp);
        end
      end
    end
    valid_input = 1'b0;
    total++;
    if (pulses.size() != 3) begin
      bad++; $display("FAIL b2b_count: got %0d want 3", pulses.size());
    end else begin
      total++;
      if (pulses[0] != 34 || pulses[1] - pulses[0] != 34 || pulses[2] - pulses[1] != 34) begin
        bad++; $display("FAIL b2b_spacing: got %0d,%0d,%0d want 34,68,102", pulses[0], pulses[1], pulses[2]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_directed();
    test_div_zero();
    test_random();
    test_reset_mid_op();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
